// File: rtl/conv_frame_ctrl.sv
// -----------------------------------------------------------------------------
// conv_frame_ctrl
//
// Frame controller for a 3x3 convolution datapath. It accepts a raster-order
// pixel stream, forwards each frame pixel to the datapath with a one-cycle
// advance strobe, and tags the datapath results whose 3x3 window lies fully
// inside the image. These are the "interior" results. It also flags pixels
// that carry a start-of-frame marker in the middle of a frame.
//
// Parameters
//   WORD_SIZE  pixel width in bits
//   ROW_SIZE   pixels per row (at least 3 for any interior result)
//   NUM_ROWS   rows per frame (at least 3)
//   CONV_LAT   cycles from conv_en to the matching datapath result (1..8)
//
// Ports
//   clk         single clock; all logic on its rising edge
//   rst         synchronous active-low reset
//   in_pixel    upstream pixel
//   in_valid    upstream pixel present
//   in_sof      first pixel of a frame (qualified by in_valid)
//   in_ready    block accepts the pixel this cycle
//   conv_en     one-cycle advance strobe to the datapath
//   conv_pixel  pixel presented with conv_en (holds between strobes)
//   out_valid   datapath result this cycle belongs to an interior pixel
//   out_sof     first interior result of the frame
//   out_eof     last interior result of the frame
//   busy        high whenever the controller is not IDLE
//   frame_err   sticky: a start-of-frame marker arrived mid-frame
// -----------------------------------------------------------------------------
module conv_frame_ctrl #(
    parameter int WORD_SIZE = 8,
    parameter int ROW_SIZE  = 540,
    parameter int NUM_ROWS  = 480,
    parameter int CONV_LAT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WORD_SIZE-1:0] in_pixel,
    input  logic                 in_valid,
    input  logic                 in_sof,
    output logic                 in_ready,
    output logic                 conv_en,
    output logic [WORD_SIZE-1:0] conv_pixel,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic                 busy,
    output logic                 frame_err
);

    localparam int COL_W = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(NUM_ROWS - 1);
    localparam logic [3:0]       DRN_LAST = 4'(CONV_LAT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ROW_W-1:0]       r_row;       // row of the next expected pixel
    logic [COL_W-1:0]       r_col;       // column of the next expected pixel
    logic [3:0]             r_drain;     // cycles spent in DRAIN so far
    logic                   r_conv_en;
    logic [WORD_SIZE-1:0]   r_conv_pixel;
    logic                   r_frame_err;

    // Tag that travels alongside the conv_en of the same pixel.
    logic                   r_tag_vld;
    logic                   r_tag_sof;
    logic                   r_tag_eof;

    // Tag delay line: stage CONV_LAT-1 lines up with the datapath result.
    logic [CONV_LAT-1:0]    r_pipe_vld;
    logic [CONV_LAT-1:0]    r_pipe_sof;
    logic [CONV_LAT-1:0]    r_pipe_eof;

    logic w_ready;
    logic w_accept;
    logic w_start;
    logic w_restart;
    logic w_run_pix;
    logic w_interior;
    logic w_first_int;
    logic w_last;
    logic w_at_origin;

    assign w_ready     = (r_state != DRAIN);
    assign w_accept    = in_valid && w_ready;
    assign w_at_origin = (r_row == '0) && (r_col == '0);

    // IDLE only wakes on a start-of-frame pixel; anything else is dropped.
    assign w_start     = w_accept && in_sof && (r_state == IDLE);

    // A start-of-frame marker anywhere but the origin of the current frame
    // restarts the frame at that pixel and discards in-flight tags.
    assign w_restart   = w_accept && in_sof && (r_state == RUN) && !w_at_origin;

    assign w_run_pix   = w_accept && (r_state == RUN) && !w_restart;

    // Pixel (r,c) with r>=2, c>=2 closes the 3x3 window centred on (r-1,c-1).
    assign w_interior  = w_run_pix && (r_row >= ROW_TWO) && (r_col >= COL_TWO);
    assign w_first_int = w_run_pix && (r_row == ROW_TWO) && (r_col == COL_TWO);
    assign w_last      = w_run_pix && (r_row == ROW_LAST) && (r_col == COL_LAST);

    // -------------------------------------------------------------------------
    // Control FSM, counters and registered datapath strobe.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_drain      <= '0;
            r_conv_en    <= 1'b0;
            r_conv_pixel <= '0;
            r_tag_vld    <= 1'b0;
            r_tag_sof    <= 1'b0;
            r_tag_eof    <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_conv_en <= w_start || w_restart || w_run_pix;
            if (w_start || w_restart || w_run_pix) begin
                r_conv_pixel <= in_pixel;
            end

            r_tag_vld <= w_interior;
            r_tag_sof <= w_first_int;
            r_tag_eof <= w_last;

            if (w_restart) begin
                r_frame_err <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    r_drain <= '0;
                    if (w_start) begin
                        // The accepted pixel is (0,0); expect (0,1) next.
                        r_state <= RUN;
                        r_row   <= '0;
                        r_col   <= COL_ONE;
                    end
                end

                RUN: begin
                    if (w_restart) begin
                        r_row <= '0;
                        r_col <= COL_ONE;
                    end else if (w_last) begin
                        r_state <= DRAIN;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_drain <= '0;
                    end else if (w_run_pix) begin
                        if (r_col == COL_LAST) begin
                            r_col <= '0;
                            r_row <= r_row + ROW_ONE;
                        end else begin
                            r_col <= r_col + COL_ONE;
                        end
                    end
                end

                DRAIN: begin
                    // Hold off upstream for CONV_LAT+1 cycles so the final
                    // tag (carrying out_eof) leaves the delay line first.
                    if (r_drain == DRN_LAST) begin
                        r_state <= IDLE;
                    end else begin
                        r_drain <= r_drain + 4'd1;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Tag delay line, shifted every cycle so stalls upstream do not disturb
    // results already in the datapath. A mid-frame restart empties it.
    // -------------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CONV_LAT; gi++) begin : g_tag_stage
            logic w_vld_in;
            logic w_sof_in;
            logic w_eof_in;

            if (gi == 0) begin : g_head
                assign w_vld_in = r_tag_vld;
                assign w_sof_in = r_tag_sof;
                assign w_eof_in = r_tag_eof;
            end else begin : g_tail
                assign w_vld_in = r_pipe_vld[gi-1];
                assign w_sof_in = r_pipe_sof[gi-1];
                assign w_eof_in = r_pipe_eof[gi-1];
            end

            always_ff @(posedge clk) begin
                if (!rst || w_restart) begin
                    r_pipe_vld[gi] <= 1'b0;
                    r_pipe_sof[gi] <= 1'b0;
                    r_pipe_eof[gi] <= 1'b0;
                end else begin
                    r_pipe_vld[gi] <= w_vld_in;
                    r_pipe_sof[gi] <= w_sof_in;
                    r_pipe_eof[gi] <= w_eof_in;
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Outputs. Handshake and strobe outputs are forced low while rst is held
    // so downstream logic sees a quiet interface for the whole reset window,
    // not only from the first reset edge onwards.
    // -------------------------------------------------------------------------
    assign in_ready   = rst && w_ready;
    assign conv_en    = rst && r_conv_en;
    assign conv_pixel = rst ? r_conv_pixel : '0;
    assign out_valid  = rst && r_pipe_vld[CONV_LAT-1];
    assign out_sof    = rst && r_pipe_sof[CONV_LAT-1];
    assign out_eof    = rst && r_pipe_eof[CONV_LAT-1];
    assign busy       = rst && (r_state != IDLE);
    assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for conv_frame_ctrl with a 5x4 frame and a 4-cycle datapath.
// Expected strobes and tags are queued when a pixel is driven and compared
// cycle by cycle when the DUT is due to produce them.
// -----------------------------------------------------------------------------
module tb_conv_frame_ctrl;

    localparam int RS = 5;
    localparam int NR = 4;
    localparam int L  = 4;
    localparam int W  = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] in_pixel;
    logic         in_valid;
    logic         in_sof;
    logic         in_ready;
    logic         conv_en;
    logic [W-1:0] conv_pixel;
    logic         out_valid;
    logic         out_sof;
    logic         out_eof;
    logic         busy;
    logic         frame_err;

    conv_frame_ctrl #(
        .WORD_SIZE (W),
        .ROW_SIZE  (RS),
        .NUM_ROWS  (NR),
        .CONV_LAT  (L)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_pixel   (in_pixel),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_ready   (in_ready),
        .conv_en    (conv_en),
        .conv_pixel (conv_pixel),
        .out_valid  (out_valid),
        .out_sof    (out_sof),
        .out_eof    (out_eof),
        .busy       (busy),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [W-1:0] pix;
    } conv_exp_t;

    typedef struct {
        int cyc;
        bit sof;
        bit eof;
    } out_exp_t;

    conv_exp_t    cq[$];
    out_exp_t     oq[$];
    int           cyc;
    int           checks;
    int           errors;
    int           n_res;
    bit           m_err;
    logic [W-1:0] m_last_pix;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        bit       exp_c;
        bit       exp_o;
        out_exp_t oe;
        exp_c = (cq.size() > 0) && (cq[0].cyc == cyc);
        chk("conv_en", 32'(conv_en), 32'(exp_c));
        if (exp_c) begin
            chk("conv_pixel", 32'(conv_pixel), 32'(cq[0].pix));
            m_last_pix = cq[0].pix;
            void'(cq.pop_front());
        end else begin
            chk("conv_pixel_hold", 32'(conv_pixel), 32'(m_last_pix));
        end

        exp_o = (oq.size() > 0) && (oq[0].cyc == cyc);
        oe.cyc = 0;
        oe.sof = 1'b0;
        oe.eof = 1'b0;
        if (exp_o) oe = oq[0];
        chk("out_valid", 32'(out_valid), 32'(exp_o));
        chk("out_sof", 32'(out_sof), 32'(oe.sof));
        chk("out_eof", 32'(out_eof), 32'(oe.eof));
        if (out_valid === 1'b1) n_res++;
        if (exp_o) begin
            $display("result cycle=%0d sof=%0d eof=%0d", cyc, oe.sof, oe.eof);
            void'(oq.pop_front());
        end

        chk("frame_err", 32'(frame_err), 32'(m_err));
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check_outputs();
    endtask

    task automatic idle_tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
        tick();
    endtask

    // Drive one pixel. idx is its raster index within the expected frame,
    // or -1 for a pixel that must be discarded. err marks a mid-frame sof.
    task automatic send(input bit sof, input logic [W-1:0] pix, input int idx, input bit err);
        conv_exp_t ce;
        out_exp_t  oe;
        int        r;
        int        c;
        in_valid = 1'b1;
        in_sof   = sof;
        in_pixel = pix;
        chk("in_ready", 32'(in_ready), 32'd1);
        if (idx >= 0) begin
            if (err) begin
                oq.delete();
                m_err = 1'b1;
            end
            ce.cyc = cyc + 1;
            ce.pix = pix;
            cq.push_back(ce);
            r = idx / RS;
            c = idx % RS;
            if (r >= 2 && c >= 2) begin
                oe.cyc = cyc + 1 + L;
                oe.sof = (r == 2) && (c == 2);
                oe.eof = (r == NR - 1) && (c == RS - 1);
                oq.push_back(oe);
            end
        end
        tick();
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic send_frame(input int base, input bit gap);
        n_res = 0;
        for (int k = 0; k < RS * NR; k++) begin
            send(k == 0, W'(base + k), k, 1'b0);
            if (k == 0) chk("busy_run", 32'(busy), 32'd1);
            if (gap && k < RS * NR - 1) idle_tick();
        end
    endtask

    // Count the DRAIN back-pressure window, then confirm the frame closed.
    task automatic finish_frame(input bit hold_next, input logic [W-1:0] next_pix);
        int cnt;
        cnt = 0;
        in_valid = hold_next;
        in_sof   = hold_next;
        in_pixel = next_pix;
        while (in_ready !== 1'b1 && cnt < 20) begin
            tick();
            cnt++;
        end
        chk("drain_len", 32'(cnt), 32'(L + 1));
        chk("results", 32'(n_res), 32'((NR - 2) * (RS - 2)));
        chk("pending", 32'(oq.size()), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
    endtask

    task automatic err_frame(input int pos);
        n_res = 0;
        for (int k = 0; k < pos; k++) send(k == 0, W'(k), k, 1'b0);
        send(1'b1, W'(50), 0, 1'b1);
        for (int k = 1; k < RS * NR; k++) send(1'b0, W'(50 + k), k, 1'b0);
        finish_frame(1'b0, '0);
    endtask

    initial begin
        cyc        = 0;
        checks     = 0;
        errors     = 0;
        n_res      = 0;
        m_err      = 1'b0;
        m_last_pix = '0;
        rst        = 1'b0;
        in_valid   = 1'b0;
        in_sof     = 1'b0;
        in_pixel   = '0;

        // Reset state.
        tick();
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        #1;
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();

        // Plain frame, continuous valid.
        send_frame(0, 1'b0);
        finish_frame(1'b0, '0);

        // Same frame with a bubble after every pixel.
        send_frame(0, 1'b1);
        finish_frame(1'b0, '0);

        // Non-sof pixels in IDLE are dropped, then a normal frame.
        for (int i = 0; i < 3; i++) send(1'b0, W'(200 + i), -1, 1'b0);
        send_frame(0, 1'b0);
        finish_frame(1'b1, W'(100));

        // Back-to-back: next frame offered throughout DRAIN.
        send_frame(100, 1'b0);
        finish_frame(1'b0, '0);

        // Mid-frame sof at index 8, then at index 13 with a tag in flight.
        err_frame(8);
        chk("err_sticky", 32'(frame_err), 32'd1);
        err_frame(13);
        chk("err_sticky2", 32'(frame_err), 32'd1);

        // Reset in the middle of a frame.
        n_res = 0;
        for (int k = 0; k < 10; k++) send(k == 0, W'(k), k, 1'b0);
        rst      = 1'b0;
        in_valid = 1'b1;
        in_sof   = 1'b0;
        in_pixel = W'(10);
        #1;
        chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
        chk("mid_rst_conv_en", 32'(conv_en), 32'd0);
        chk("mid_rst_conv_pixel", 32'(conv_pixel), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        cq.delete();
        oq.delete();
        m_err      = 1'b0;
        m_last_pix = '0;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_conv_pixel", 32'(conv_pixel), 32'd0);
        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int k = 11; k < 14; k++) send(1'b0, W'(k), -1, 1'b0);
        idle_tick();
        chk("post_rst_no_results", 32'(n_res), 32'd0);
        send_frame(30, 1'b0);
        finish_frame(1'b0, '0);
        for (int i = 0; i < 3; i++) idle_tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
